lsu_memory: RTL
===============

LSU_MEMORY -- requirements
Module: lsu_memory

Interface
REQ-001 SHALL have parameter W, default 32, data width in bits; legal values are 32 only this generation, and elaboration SHALL fail otherwise.
REQ-002 SHALL have parameter D, default 10, byte-address width; word depth is 2**(D-2).
REQ-003 SHALL have parameter INIT_FILE, default "" (empty), a hex image loaded at elaboration when non-empty.
REQ-004 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-005 i_reset_n  in  1  asynchronous, active-low reset.
REQ-006 i_req_valid  in  1  request present.
REQ-007 o_req_ready  out  1  request accepted when valid&&ready at a clock edge.
REQ-008 i_req_we  in  1  1=store, 0=load.
REQ-009 i_req_size  in  2  access size: 00 byte, 01 half, 10 word; 11 is illegal.
REQ-010 i_req_unsigned  in  1  load zero-extends when 1, sign-extends when 0; ignored for stores and word loads.
REQ-011 i_req_addr  in  D  byte address.
REQ-012 i_req_wdata  in  W  store data, LSB-justified.
REQ-013 o_rsp_valid  out  1  response present.
REQ-014 i_rsp_ready  in  1  response consumed when valid&&ready.
REQ-015 o_rsp_rdata  out  W  load result, extended; 0 for stores and errors.
REQ-016 o_rsp_err  out  1  request was misaligned or had illegal size.

Function
REQ-017 Each accepted request SHALL produce exactly one response, in order.
REQ-018 o_req_ready SHALL equal !o_rsp_valid || i_rsp_ready, allowing one request per cycle at full throughput.
REQ-019 Response SHALL appear in the cycle after acceptance (latency 1), and o_rsp_* SHALL hold stable while o_rsp_valid && !i_rsp_ready.
REQ-020 Word index SHALL be i_req_addr[D-1:2], and byte lane SHALL be i_req_addr[1:0].
REQ-021 Misaligned requests (half with addr[0]=1, word with addr[1:0]!=0) and size 11 SHALL set o_rsp_err=1, SHALL not modify memory, and SHALL return rdata 0.
REQ-022 A byte store SHALL write only lane addr[1:0], with data wdata[7:0].
REQ-023 A half store SHALL write lanes addr[1]*2 and addr[1]*2+1, with data wdata[15:0].
REQ-024 A word store SHALL write all four lanes; untouched lanes SHALL keep their old value.
REQ-025 Loads SHALL extract the addressed byte or half, then sign- or zero-extend it to W per i_req_unsigned.
REQ-026 A load accepted the cycle after a store to the same word SHALL return the post-store data, since the store commits at acceptance edge.
REQ-027 Two-state FSM: EMPTY (o_rsp_valid=0) and FULL (o_rsp_valid=1).
REQ-028 FSM transitions: EMPTY->FULL on accept; FULL->EMPTY on rsp handshake without accept; FULL->FULL on simultaneous rsp handshake and accept, with the new response loaded.
REQ-029 Request fields SHALL be ignored when i_req_valid=0 or o_req_ready=0.

Reset
REQ-030 Asserting i_reset_n=0 SHALL asynchronously force FSM=EMPTY, o_rsp_valid=0, o_rsp_rdata=0 and o_rsp_err=0.
REQ-031 Memory contents SHALL NOT be reset.
REQ-032 A request presented in the same edge that reset releases SHALL be ignored.
REQ-033 A response pending when reset asserts SHALL be discarded.
REQ-034 No store SHALL commit while i_reset_n=0.

Structure
REQ-035 Shared package riscv_pkg SHALL hold size encodings SIZE_B/SIZE_H/SIZE_W and the alignment-check function.
REQ-036 Byte-lane steering (store write-enable/data replication, load extraction/extension) SHALL live in combinational sub-module lsu_align.
REQ-037 The memory array SHALL be byte-enabled, with one write port and one synchronous read port.

Verification
REQ-038 Store word 0xDEADBEEF @0x10, then load word @0x10 -> rdata 0xDEADBEEF, err 0.
REQ-039 After REQ-038, store byte 0x5A @0x12, then load word @0x10 -> 0xDE5ABEEF; load signed byte @0x13 -> 0xFFFFFFDE; load unsigned half @0x12 -> 0x0000DE5A.
REQ-040 Load word @0x11, store half @0x13 and size 11 @0x10 -> err 1 and rdata 0 each; subsequent load word @0x10 returns unchanged 0xDE5ABEEF.
REQ-041 Hold i_rsp_ready=0 for 3 cycles with back-to-back loads -> o_req_ready=0 and response stable; then i_rsp_ready=1 continuous -> one response per cycle, in order.
REQ-042 Assert i_reset_n=0 while o_rsp_valid=1 -> o_rsp_valid=0 immediately; after release, memory retains prior data.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared load/store encodings: access sizes, response-slot states and the alignment rule.
package riscv_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rsp_state_e;

  // True for an illegal size or an address not aligned to the access size.
  function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = lane[0];
      SIZE_W:  bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering, purely combinational: store byte-enables/replicated data on the request side,
// load extraction and sign/zero extension on the response side.
module lsu_align
  import riscv_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [1:0]     st_size_i,
  input  logic [1:0]     st_lane_i,
  input  logic [W-1:0]   st_wdata_i,
  output logic [W/8-1:0] st_be_o,
  output logic [W-1:0]   st_word_o,
  input  logic [1:0]     ld_size_i,
  input  logic [1:0]     ld_lane_i,
  input  logic           ld_unsigned_i,
  input  logic [W-1:0]   ld_word_i,
  output logic [W-1:0]   ld_data_o
);

  logic [W-1:0] ld_shifted;

  always_comb begin
    st_be_o   = '0;
    st_word_o = st_wdata_i;
    case (st_size_i)
      SIZE_B: begin
        st_be_o   = 4'b0001 << st_lane_i;
        st_word_o = {(W/8){st_wdata_i[7:0]}};
      end
      SIZE_H: begin
        st_be_o   = st_lane_i[1] ? 4'b1100 : 4'b0011;
        st_word_o = {(W/16){st_wdata_i[15:0]}};
      end
      SIZE_W: st_be_o = '1;
      default: st_be_o = '0;
    endcase
  end

  // Shifting the addressed lane down to bit 0 makes byte and half extraction uniform.
  assign ld_shifted = ld_word_i >> {ld_lane_i, 3'b000};

  always_comb begin
    ld_data_o = '0;
    case (ld_size_i)
      SIZE_B:  ld_data_o = {{(W-8){ld_shifted[7] & ~ld_unsigned_i}}, ld_shifted[7:0]};
      SIZE_H:  ld_data_o = {{(W-16){ld_shifted[15] & ~ld_unsigned_i}}, ld_shifted[15:0]};
      SIZE_W:  ld_data_o = ld_word_i;
      default: ld_data_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_memory.sv
// Byte-enabled data memory with a one-entry response slot: 1-cycle latency, stores commit at acceptance.
// Backpressure: a request is accepted only while the slot is empty or its response is consumed that same cycle.
module lsu_memory
  import riscv_pkg::*;
#(
  parameter int    W         = 32,
  parameter int    D         = 10,
  parameter string INIT_FILE = ""
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_req_valid,
  output logic         o_req_ready,
  input  logic         i_req_we,
  input  logic [1:0]   i_req_size,
  input  logic         i_req_unsigned,
  input  logic [D-1:0] i_req_addr,
  input  logic [W-1:0] i_req_wdata,
  output logic         o_rsp_valid,
  input  logic         i_rsp_ready,
  output logic [W-1:0] o_rsp_rdata,
  output logic         o_rsp_err
);

  localparam int DEPTH = 1 << (D - 2);
  localparam int NB    = W / 8;

  if (W != 32) begin : g_bad_width
    $error("lsu_memory: only W=32 is supported");
  end

  rsp_state_e     state_q, state_d;
  logic           live_q;
  logic           accept, rsp_hs, req_err;
  logic [D-3:0]   idx;
  logic           we_q, err_q, uns_q;
  logic [1:0]     size_q, lane_q;
  logic [W-1:0]   rd_word_q;
  logic [NB-1:0]  st_be;
  logic [W-1:0]   st_word, ld_data;
  logic [W-1:0]   mem_q [DEPTH];

  assign idx     = i_req_addr[D-1:2];
  assign req_err = is_bad_access(i_req_size, i_req_addr[1:0]);
  // live_q stays low through the first edge after reset release, so a request on that edge is dropped.
  assign accept  = i_req_valid && o_req_ready && live_q;
  assign rsp_hs  = o_rsp_valid && i_rsp_ready;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_EMPTY;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (!accept && rsp_hs) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    o_rsp_valid = (state_q == ST_FULL);
    o_req_ready = !o_rsp_valid || i_rsp_ready;
    o_rsp_err   = o_rsp_valid && err_q;
    o_rsp_rdata = (o_rsp_valid && !err_q && !we_q) ? ld_data : '0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      we_q   <= 1'b0;
      err_q  <= 1'b0;
      uns_q  <= 1'b0;
      size_q <= 2'b00;
      lane_q <= 2'b00;
    end else if (accept) begin
      we_q   <= i_req_we;
      err_q  <= req_err;
      uns_q  <= i_req_unsigned;
      size_q <= i_req_size;
      lane_q <= i_req_addr[1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept && !i_req_we) rd_word_q <= mem_q[idx];
  end

  always_ff @(posedge i_clk) begin
    if (accept && i_req_we && !req_err) begin
      for (int b = 0; b < NB; b++) begin
        if (st_be[b]) mem_q[idx][8*b +: 8] <= st_word[8*b +: 8];
      end
    end
  end

  lsu_align #(.W(W)) u_align (
    .st_size_i    (i_req_size),
    .st_lane_i    (i_req_addr[1:0]),
    .st_wdata_i   (i_req_wdata),
    .st_be_o      (st_be),
    .st_word_o    (st_word),
    .ld_size_i    (size_q),
    .ld_lane_i    (lane_q),
    .ld_unsigned_i(uns_q),
    .ld_word_i    (rd_word_q),
    .ld_data_o    (ld_data)
  );

endmodule
